// File: rtl/cla_seq_ctrl_pkg.sv
// Shared definitions for the sequential carry-lookahead add/subtract unit.
package cla_seq_ctrl_pkg;

   // Default slice width and number of slices per operation.
   localparam int unsigned W_DEF     = 4;
   localparam int unsigned WORDS_DEF = 4;

   // Controller states. Encoding 2'd3 is unused and recovers to StIdle.
   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2
   } state_e;

endpackage

// File: rtl/cla_seq_ctrl_slice.sv
// W-bit combinational carry-lookahead adder slice.
module cla_slice
   import cla_seq_ctrl_pkg::*;
#(
   parameter int unsigned W = W_DEF
) (
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_b,
   input  logic         i_cin,
   output logic [W-1:0] o_sum,
   output logic         o_cout,
   output logic         o_c_msb_in
);

   logic [W-1:0] w_g;
   logic [W-1:0] w_p;
   logic [W:0]   w_c;
   logic         w_prod;

   assign w_g = i_a & i_b;
   assign w_p = i_a ^ i_b;

   // Each carry as a flat OR of generate terms gated by the propagate chain back to cin.
   always_comb begin
      w_c    = '0;
      w_prod = 1'b0;
      w_c[0] = i_cin;
      for (int i = 0; i < int'(W); i++) begin
         w_c[i+1] = w_g[i];
         w_prod   = w_p[i];
         for (int j = i - 1; j >= 0; j--) begin
            w_c[i+1] = w_c[i+1] | (w_prod & w_g[j]);
            w_prod   = w_prod & w_p[j];
         end
         w_c[i+1] = w_c[i+1] | (w_prod & i_cin);
      end
   end

   assign o_sum      = w_p ^ w_c[W-1:0];
   assign o_cout     = w_c[W];
   assign o_c_msb_in = w_c[W-1];

endmodule

// File: rtl/cla_seq_ctrl.sv
// Wide add/subtract performed one W-bit slice per cycle through a shared CLA slice.
module cla_seq_ctrl
   import cla_seq_ctrl_pkg::*;
#(
   parameter int unsigned W     = W_DEF,
   parameter int unsigned WORDS = WORDS_DEF
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_in_valid,
   output logic               o_in_ready,
   input  logic [W*WORDS-1:0] i_op_a,
   input  logic [W*WORDS-1:0] i_op_b,
   input  logic               i_op_sub,
   output logic               o_out_valid,
   input  logic               i_out_ready,
   output logic [W*WORDS-1:0] o_sum,
   output logic               o_cout,
   output logic               o_ovf
);

   localparam int unsigned WIDE = W * WORDS;
   localparam int unsigned IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;

   state_e            r_state;
   state_e            w_state_d;
   logic [IDXW-1:0]   r_idx;
   logic              r_carry;
   logic              r_ovf;
   logic [WIDE-1:0]   r_a;
   logic [WIDE-1:0]   r_b;
   logic [WIDE-1:0]   r_res;
   logic [WIDE-1:0]   w_res_d;
   logic [W-1:0]      w_sl_a;
   logic [W-1:0]      w_sl_b;
   logic [W-1:0]      w_sl_sum;
   logic              w_sl_cout;
   logic              w_sl_cmsb;
   logic              w_accept;
   logic              w_last;

   assign w_accept = (r_state == StIdle) && i_in_valid;
   assign w_last   = (r_idx == IDXW'(WORDS - 1));

   // State register.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_d;
      end
   end

   // Next-state logic and handshake outputs.
   always_comb begin
      w_state_d   = r_state;
      o_in_ready  = 1'b0;
      o_out_valid = 1'b0;
      unique case (r_state)
         StIdle: begin
            o_in_ready = 1'b1;
            if (i_in_valid) w_state_d = StRun;
         end
         StRun: begin
            if (w_last) w_state_d = StDone;
         end
         StDone: begin
            o_out_valid = 1'b1;
            if (i_out_ready) w_state_d = StIdle;
         end
         default: w_state_d = StIdle;
      endcase
   end

   // Select the operand slice addressed by the current index.
   always_comb begin
      w_sl_a = '0;
      w_sl_b = '0;
      for (int k = 0; k < int'(WORDS); k++) begin
         if (r_idx == IDXW'(k)) begin
            w_sl_a = r_a[k*W +: W];
            w_sl_b = r_b[k*W +: W];
         end
      end
   end

   // Merge the slice sum into the result word at the current index.
   always_comb begin
      w_res_d = r_res;
      for (int k = 0; k < int'(WORDS); k++) begin
         if (r_idx == IDXW'(k)) w_res_d[k*W +: W] = w_sl_sum;
      end
   end

   cla_slice #(
      .W (W)
   ) u_slice (
      .i_a        (w_sl_a),
      .i_b        (w_sl_b),
      .i_cin      (r_carry),
      .o_sum      (w_sl_sum),
      .o_cout     (w_sl_cout),
      .o_c_msb_in (w_sl_cmsb)
   );

   // Operand capture, per-slice accumulation, carry chaining and overflow capture.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_idx   <= '0;
         r_carry <= 1'b0;
         r_ovf   <= 1'b0;
         r_a     <= '0;
         r_b     <= '0;
         r_res   <= '0;
      end else if (w_accept) begin
         r_a     <= i_op_a;
         // Subtract as A + ~B + 1; the +1 enters as the initial carry.
         r_b     <= i_op_sub ? ~i_op_b : i_op_b;
         r_carry <= i_op_sub;
         r_idx   <= '0;
      end else if (r_state == StRun) begin
         r_res   <= w_res_d;
         r_carry <= w_sl_cout;
         if (w_last) begin
            r_ovf <= w_sl_cmsb ^ w_sl_cout;
         end else begin
            r_idx <= r_idx + 1'b1;
         end
      end
   end

   assign o_sum  = r_res;
   assign o_cout = r_carry;
   assign o_ovf  = r_ovf;

endmodule

// File: tb/tb_cla_seq_ctrl.sv
// Scoreboard bench: driver queues model results, monitor checks every presented result.
module tb_cla_seq_ctrl;

   localparam int unsigned W     = 4;
   localparam int unsigned WORDS = 4;
   localparam int unsigned WIDE  = W * WORDS;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            in_valid;
   logic            in_ready;
   logic [WIDE-1:0] op_a;
   logic [WIDE-1:0] op_b;
   logic            op_sub;
   logic            out_valid;
   logic            out_ready;
   logic [WIDE-1:0] sum;
   logic            cout;
   logic            ovf;

   int checks = 0;
   int errors = 0;

   logic [WIDE+1:0] exp_q[$];

   always #5 clk = ~clk;

   cla_seq_ctrl #(
      .W     (W),
      .WORDS (WORDS)
   ) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_in_valid  (in_valid),
      .o_in_ready  (in_ready),
      .i_op_a      (op_a),
      .i_op_b      (op_b),
      .i_op_sub    (op_sub),
      .o_out_valid (out_valid),
      .i_out_ready (out_ready),
      .o_sum       (sum),
      .o_cout      (cout),
      .o_ovf       (ovf)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   // Reference: plain wide arithmetic, {sum, cout, ovf}.
   function automatic logic [WIDE+1:0] model(input logic [WIDE-1:0] a, input logic [WIDE-1:0] b,
                                             input logic sub);
      logic [WIDE:0]   full;
      logic [WIDE-1:0] s;
      logic            c;
      logic            v;
      if (sub) begin
         s = a - b;
         c = (a >= b);
         v = (a[WIDE-1] != b[WIDE-1]) && (s[WIDE-1] != a[WIDE-1]);
      end else begin
         full = {1'b0, a} + {1'b0, b};
         s    = full[WIDE-1:0];
         c    = full[WIDE];
         v    = (a[WIDE-1] == b[WIDE-1]) && (s[WIDE-1] != a[WIDE-1]);
      end
      return {s, c, v};
   endfunction

   // Monitor: every presented result must match the oldest expectation; pop on transfer.
   initial begin
      logic [WIDE+1:0] e;
      forever begin
         @(negedge clk);
         if (out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_out_valid", 32'(out_valid), 32'd0);
            end else begin
               e = exp_q[0];
               chk("sum", 32'(sum), 32'(e[WIDE+1:2]));
               chk("cout", 32'(cout), 32'(e[1]));
               chk("ovf", 32'(ovf), 32'(e[0]));
               if (out_ready) void'(exp_q.pop_front());
            end
         end
      end
   end

   task automatic wait_idle();
      int n = 0;
      while (in_ready !== 1'b1 && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (in_ready !== 1'b1) chk("idle_timeout", 32'(in_ready), 32'd1);
   endtask

   // Issue one operation; hold = cycles of out_ready=0 in DONE; scramble = wiggle inputs in RUN.
   task automatic do_op(input logic [WIDE-1:0] a, input logic [WIDE-1:0] b, input logic sub,
                        input int hold, input bit scramble);
      int n;
      bit busy_ready;
      wait_idle();
      in_valid  = 1'b1;
      op_a      = a;
      op_b      = b;
      op_sub    = sub;
      out_ready = (hold == 0);
      exp_q.push_back(model(a, b, sub));
      @(posedge clk);
      #1;
      in_valid   = scramble;
      n          = 0;
      busy_ready = 1'b0;
      @(negedge clk);
      while (out_valid !== 1'b1 && n < 50) begin
         if (in_ready !== 1'b0) busy_ready = 1'b1;
         if (scramble) begin
            op_a   = WIDE'($urandom);
            op_b   = WIDE'($urandom);
            op_sub = 1'($urandom);
         end
         n++;
         @(negedge clk);
      end
      in_valid = 1'b0;
      chk("latency", 32'(n), 32'(WORDS));
      chk("in_ready_during_run", 32'(busy_ready), 32'd0);
      if (hold > 0) begin
         repeat (hold) begin
            @(posedge clk);
            #1;
            chk("in_ready_in_done", 32'(in_ready), 32'd0);
            chk("out_valid_held", 32'(out_valid), 32'd1);
         end
         out_ready = 1'b1;
      end
      @(posedge clk);
      #1;
      chk("out_valid_drop", 32'(out_valid), 32'd0);
      chk("in_ready_back", 32'(in_ready), 32'd1);
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      op_a      = '0;
      op_b      = '0;
      op_sub    = 1'b0;
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_sum", 32'(sum), 32'd0);
      chk("rst_cout", 32'(cout), 32'd0);
      chk("rst_ovf", 32'(ovf), 32'd0);
      @(posedge clk);
      #1;

      do_op(16'h00FF, 16'h0001, 1'b0, 0, 1'b0);
      do_op(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0);
      do_op(16'h7FFF, 16'h0001, 1'b0, 0, 1'b0);
      do_op(16'h0005, 16'h0007, 1'b1, 0, 1'b0);
      do_op(16'h1234, 16'h1111, 1'b0, 10, 1'b0);
      do_op(16'hAAAA, 16'h5555, 1'b0, 0, 1'b1);

      // Reset during the second RUN cycle discards the operation.
      wait_idle();
      in_valid  = 1'b1;
      op_a      = 16'h1111;
      op_b      = 16'h2222;
      op_sub    = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("midrst_in_ready", 32'(in_ready), 32'd1);
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_sum", 32'(sum), 32'd0);
      chk("midrst_cout", 32'(cout), 32'd0);
      chk("midrst_ovf", 32'(ovf), 32'd0);
      @(posedge clk);
      #1;
      do_op(16'h0003, 16'h0004, 1'b0, 0, 1'b0);

      for (int i = 0; i < 30; i++) begin
         do_op(WIDE'($urandom), WIDE'($urandom), 1'($urandom), int'($urandom_range(0, 3)), 1'b0);
      end

      repeat (5) @(posedge clk);
      #1;
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Watchdog in case the handshake never completes.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule

// File: doc/cla_seq_ctrl.md
Name: cla_seq_ctrl

Overview:
- Sequencer that performs one WIDE-bit add or subtract by time-multiplexing a single W-bit carry-lookahead adder slice over WORDS cycles.
- A carry flip-flop links consecutive slices.
- Operands enter, and results leave, through valid/ready handshakes.
- Sits between operand sources and result consumers wherever a full-width CLA would cost too much area.

Parameters:
- W, 4, width of the shared CLA slice in bits
- WORDS, 4, number of slices per operation; WIDE = W*WORDS (default 16)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  operand request valid
- in_ready  out  1  block can accept operands
- op_a  in  WIDE  operand A
- op_b  in  WIDE  operand B
- op_sub  in  1  1 = A-B, 0 = A+B
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- sum  out  WIDE  result, modulo 2^WIDE
- cout  out  1  carry out of MSB (for subtract: 1 = no borrow)
- ovf  out  1  signed two's-complement overflow

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (rst_n), sampled on the rising edge of clk.
- Reset (rst_n=0 at a clk edge):
  - state=IDLE, slice index=0, carry register=0.
  - Internal operand and result registers, sum, cout and ovf are all cleared to 0.
  - in_ready=1 and out_valid=0 in the cycle following reset.
  - Reset overrides any in-flight operation; the partial result is discarded and no out_valid pulse occurs.
- State machine (IDLE, RUN, DONE):
  - IDLE:
    - in_ready=1, out_valid=0.
    - On in_valid=1, capture op_a into a_reg.
    - Capture op_b, or ~op_b when op_sub=1, into b_reg.
    - Load carry register with op_sub, set idx=0, go to RUN.
  - RUN:
    - in_ready=0, out_valid=0.
    - Each cycle the slice computes a_reg[idx*W +: W] + b_reg[idx*W +: W] + carry.
    - The W-bit sum is written to res[idx*W +: W] and the slice carry-out to the carry register.
    - On idx=WORDS-1, also capture ovf = carry-into-MSB XOR carry-out-of-MSB, then go to DONE.
    - Otherwise idx increments.
  - DONE:
    - out_valid=1; sum=res, cout=carry register, ovf held stable.
    - On out_ready=1, go to IDLE; out_valid drops the next cycle.
    - With out_ready=0 the block stays in DONE indefinitely and all outputs are held.
- Latency:
  - Operands are accepted at edge T; out_valid is first high in the cycle after edge T+WORDS.
  - Minimum period between accepts: WORDS+2 cycles. There is no overlap; in_ready=0 outside IDLE.
- Handshake rules:
  - A transfer occurs only on valid&&ready at a clk edge.
  - op_a, op_b and op_sub are sampled only at the accept edge; later changes are ignored.
  - out_ready asserted outside DONE has no effect.
- Width and arithmetic:
  - sum wraps modulo 2^WIDE.
  - Subtraction is A + ~B + 1, with the +1 supplied as the initial carry.
  - WORDS=1 is legal: RUN lasts one cycle.
- Slice adder:
  - Purely combinational W-bit CLA.
  - Generate g=a&b, propagate p=a^b; carries c[i+1] = g[i] | p[i]&c[i], computed in lookahead form.

Decomposition:
- Shared package holds:
  - State encoding constants: IDLE=2'd0, RUN=2'd1, DONE=2'd2. Encoding 2'd3 is illegal and must recover to IDLE.
  - Default W and WORDS values.
- One sub-module: cla_slice (W-bit combinational lookahead adder, ports a, b, cin, sum, cout, c_msb_in). Instantiated once.
- cla_seq_ctrl contains:
  - the FSM;
  - the slice index counter (clog2(WORDS) bits, minimum 1);
  - the carry register;
  - the operand and result registers.

Test Plan:
- Reset, then add 0x00FF+0x0001 with out_ready=1 -> out_valid high in the cycle after accept edge +4; sum=0x0100, cout=0, ovf=0; in_ready back to 1 two cycles later.
- Add 0xFFFF+0x0001 -> sum=0x0000, cout=1, ovf=0 (carry ripples through all 4 slices).
- Add 0x7FFF+0x0001 -> sum=0x8000, cout=0, ovf=1. Then subtract 0x0005-0x0007 (op_sub=1) -> sum=0xFFFE, cout=0 (borrow), ovf=0.
- Backpressure: 0x1234+0x1111 with out_ready=0 for 10 cycles -> out_valid stays 1 and sum=0x2345 stable; in_ready=0 throughout; one transfer when out_ready=1.
- Operand change after accept: drive 0xAAAA+0x5555, change op_a/op_b/in_valid each cycle during RUN -> sum=0xFFFF, cout=0, and no second accept occurs.
- Reset mid-operation: assert rst_n=0 at the second RUN cycle -> next cycle in_ready=1, out_valid=0, and sum, cout and ovf read 0. A new add 0x0003+0x0004 then returns sum=0x0007 with normal latency.
